// File: rtl/apu_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// apu_cmd_sequencer_if
//   Bundles the byte-stream input and register-write output of the APU command
//   sequencer.
//   master : host/bench side, drives rx_valid/rx_data, observes the results
//   slave  : sequencer side, consumes bytes, drives the register write port
// Signals
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte (8), meaningful only while rx_valid=1
//   reg_we     one-cycle APU register write strobe
//   reg_addr   APU register index (5), holds the last write
//   reg_data   APU register data (8), holds the last write
//   frame_err  one-cycle strobe on any rejected byte or frame
//   link       stretched link-activity status
//   state      parser FSM state, exported for observation
// Handshake: there is no back-pressure. A byte is consumed on every rising edge
// where rx_valid=1, including on consecutive cycles; outputs are registered.
// ----------------------------------------------------------------------------
interface apu_cmd_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       reg_we;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       frame_err;
    logic       link;
    logic [1:0] state;

    modport master (
        output rx_valid, rx_data,
        input  reg_we, reg_addr, reg_data, frame_err, link, state
    );

    modport slave (
        input  rx_valid, rx_data,
        output reg_we, reg_addr, reg_data, frame_err, link, state
    );
endinterface

// File: rtl/apu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// apu_cmd_sequencer
//   Parses the serial host byte stream into APU register writes. Each write is
//   a 3-byte frame ADDR, DATA, CHK with CHK = {3'b0,addr} ^ data ^ 8'h5A.
//   An inter-byte gap timer drops partial frames, and a retriggerable hold
//   timer drives the link-activity status.
// Ports
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  slave modport of apu_cmd_sequencer_if (byte input, write output,
//        frame_err, link, state)
// ----------------------------------------------------------------------------
module apu_cmd_sequencer #(
    parameter int OSCRATE     = 12_000_000,
    parameter int BAUDRATE    = 9600,
    parameter int GAP_BYTES   = 2,
    parameter int LINK_CYCLES = 1_200_000
) (
    input  logic                  clk,
    input  logic                  rst,
    apu_cmd_sequencer_if.slave    bus
);
    // One byte on the wire is 10 bit times (start + 8 data + stop).
    localparam int TIMEOUT = GAP_BYTES * 10 * OSCRATE / BAUDRATE;
    // The gap counter only ever reaches TIMEOUT-1.
    localparam int GAP_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // +1 so that a power-of-two LINK_CYCLES still fits in the hold counter.
    localparam int LINK_W  = $clog2(LINK_CYCLES + 1);

    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [LINK_W-1:0] LINK_LOAD = LINK_W'(LINK_CYCLES);
    localparam logic [LINK_W-1:0] LINK_ONE  = LINK_W'(1);

    localparam logic [1:0] S_ADDR = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [4:0]        addr_q,      addr_d;
    logic [7:0]        data_q,      data_d;
    logic              reg_we_q,    reg_we_d;
    logic [4:0]        reg_addr_q,  reg_addr_d;
    logic [7:0]        reg_data_q,  reg_data_d;
    logic              frame_err_q, frame_err_d;
    logic [GAP_W-1:0]  gap_q,       gap_d;
    logic [LINK_W-1:0] link_q,      link_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        frame_err_d = 1'b0;

        // Gap timer: cleared by every byte, otherwise counts and saturates.
        if (bus.rx_valid) begin
            gap_d = '0;
        end else if (gap_q != GAP_LAST) begin
            gap_d = gap_q + GAP_ONE;
        end else begin
            gap_d = gap_q;
        end

        link_d = (link_q != '0) ? (link_q - LINK_ONE) : link_q;

        // A byte arriving on the timeout cycle takes priority over the timeout.
        if (bus.rx_valid) begin
            case (state_q)
                S_ADDR: begin
                    if (bus.rx_data <= 8'h17) begin
                        addr_d  = bus.rx_data[4:0];
                        state_d = S_DATA;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    data_d  = bus.rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    if (bus.rx_data == ({3'b000, addr_q} ^ data_q ^ 8'h5A)) begin
                        reg_we_d   = 1'b1;
                        reg_addr_d = addr_q;
                        reg_data_d = data_q;
                        link_d     = LINK_LOAD;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_ADDR;
                end
                default: state_d = S_ADDR;
            endcase
        end else if ((state_q != S_ADDR) && (gap_q == GAP_LAST)) begin
            // Partial frame stalled too long: resync on the next byte.
            state_d     = S_ADDR;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ADDR;
            addr_q      <= '0;
            data_q      <= '0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            frame_err_q <= 1'b0;
            gap_q       <= '0;
            link_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            frame_err_q <= frame_err_d;
            gap_q       <= gap_d;
            link_q      <= link_d;
        end
    end

    assign bus.reg_we    = reg_we_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_data  = reg_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.link      = (link_q != '0);
    assign bus.state     = state_q;
endmodule

// File: tb/tb_apu_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_apu_cmd_sequencer
//   Directed bench for apu_cmd_sequencer with shortened timing parameters:
//   TIMEOUT = 2*10*96000/9600 = 200 cycles, LINK_CYCLES = 1200.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_apu_cmd_sequencer;
    localparam int TO   = 200;
    localparam int LINK = 1200;

    localparam logic [1:0] S_ADDR = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_CHK  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apu_cmd_sequencer_if bus ();

    apu_cmd_sequencer #(
        .OSCRATE    (96_000),
        .BAUDRATE   (9600),
        .GAP_BYTES  (2),
        .LINK_CYCLES(LINK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the falling edge after the byte's
    // sampling edge, so registered results of that byte are visible on return.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " reg_we"},    {31'd0, bus.reg_we},    32'd0);
        chk({tag, " reg_addr"},  {27'd0, bus.reg_addr},  32'd0);
        chk({tag, " reg_data"},  {24'd0, bus.reg_data},  32'd0);
        chk({tag, " frame_err"}, {31'd0, bus.frame_err}, 32'd0);
        chk({tag, " link"},      {31'd0, bus.link},      32'd0);
        chk({tag, " state"},     {30'd0, bus.state},     {30'd0, S_ADDR});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic       we, err, link;
        logic [4:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic we, input logic err,
                                input logic [4:0] addr, input logic [7:0] data);
        vec_t v;
        v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.we = we; v.err = err; v.link = 1'b1; v.addr = addr; v.data = data;
        return v;
    endfunction

    initial begin
        int first;
        int pulses;
        logic [7:0] bytes [3];

        vecs[0] = mk(3, 8'h15, 8'h0F, 8'h40, 1'b1, 1'b0, 5'h15, 8'h0F); // good write
        vecs[1] = mk(3, 8'h15, 8'h0F, 8'h41, 1'b0, 1'b1, 5'h15, 8'h0F); // bad checksum
        vecs[2] = mk(3, 8'h02, 8'h80, 8'hD8, 1'b1, 1'b0, 5'h02, 8'h80); // resync write
        vecs[3] = mk(1, 8'h18, 8'h00, 8'h00, 1'b0, 1'b1, 5'h02, 8'h80); // addr just out of range
        vecs[4] = mk(3, 8'h00, 8'h30, 8'h6A, 1'b1, 1'b0, 5'h00, 8'h30); // lowest addr
        vecs[5] = mk(3, 8'h17, 8'hFF, 8'hB2, 1'b1, 1'b0, 5'h17, 8'hFF); // highest addr
        vecs[6] = mk(1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 5'h17, 8'hFF); // addr 0xFF rejected

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // ---- reset ----
        idle(3);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post reset");

        // ---- table-driven frames, sent back to back ----
        for (int v = 0; v < 7; v++) begin
            bytes[0] = vecs[v].b0;
            bytes[1] = vecs[v].b1;
            bytes[2] = vecs[v].b2;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(bytes[i]);
                if (i < vecs[v].n - 1) begin
                    chk($sformatf("v%0d b%0d reg_we", v, i), {31'd0, bus.reg_we}, 32'd0);
                    chk($sformatf("v%0d b%0d frame_err", v, i), {31'd0, bus.frame_err}, 32'd0);
                end
            end
            chk($sformatf("v%0d reg_we", v),    {31'd0, bus.reg_we},    {31'd0, vecs[v].we});
            chk($sformatf("v%0d frame_err", v), {31'd0, bus.frame_err}, {31'd0, vecs[v].err});
            chk($sformatf("v%0d reg_addr", v),  {27'd0, bus.reg_addr},  {27'd0, vecs[v].addr});
            chk($sformatf("v%0d reg_data", v),  {24'd0, bus.reg_data},  {24'd0, vecs[v].data});
            chk($sformatf("v%0d link", v),      {31'd0, bus.link},      {31'd0, vecs[v].link});
            chk($sformatf("v%0d state", v),     {30'd0, bus.state},     {30'd0, S_ADDR});
        end
        idle(1);
        chk("tail reg_we", {31'd0, bus.reg_we}, 32'd0);
        chk("tail frame_err", {31'd0, bus.frame_err}, 32'd0);

        // ---- byte arriving on the timeout cycle wins ----
        send_byte(8'h04);
        idle(TO - 1);
        send_byte(8'h22);
        chk("race frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("race state", {30'd0, bus.state}, {30'd0, S_CHK});
        send_byte(8'h7C);
        chk("race reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("race reg_addr", {27'd0, bus.reg_addr}, 32'h04);
        chk("race reg_data", {24'd0, bus.reg_data}, 32'h22);

        // ---- gap timeout in S_DATA, single pulse, nothing further in S_ADDR ----
        send_byte(8'h03);
        chk("to state data", {30'd0, bus.state}, {30'd0, S_DATA});
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 2 * TO; k++) begin
            @(negedge clk);
            if (bus.frame_err) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("to pulses", pulses, 32'd1);
        chk("to cycle", first, TO);
        chk("to state", {30'd0, bus.state}, {30'd0, S_ADDR});
        send_frame(8'h03, 8'h11, 8'h48);
        chk("to wr reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("to wr reg_addr", {27'd0, bus.reg_addr}, 32'h03);
        chk("to wr reg_data", {24'd0, bus.reg_data}, 32'h11);

        // ---- link retrigger: second write 600 cycles after the first ----
        idle(LINK + 5);
        chk("link idle", {31'd0, bus.link}, 32'd0);
        send_frame(8'h01, 8'h02, 8'h59);
        chk("link w1 reg_we", {31'd0, bus.reg_we}, 32'd1);
        chk("link w1 rise", {31'd0, bus.link}, 32'd1);
        idle(597);
        send_frame(8'h06, 8'h07, 8'h5B);
        chk("link w2 reg_we", {31'd0, bus.reg_we}, 32'd1);
        idle(600);
        chk("link past w1 hold", {31'd0, bus.link}, 32'd1);
        idle(599);
        chk("link last cycle", {31'd0, bus.link}, 32'd1);
        idle(1);
        chk("link fall", {31'd0, bus.link}, 32'd0);

        // ---- reset in the middle of a frame ----
        send_byte(8'h05);
        send_byte(8'h10);
        rst = 1'b1;
        #1;
        chk_all_zero("mid reset async");
        idle(2);
        chk_all_zero("mid reset hold");
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h40);
        chk("after rst frame_err", {31'd0, bus.frame_err}, 32'd1);
        chk("after rst reg_we", {31'd0, bus.reg_we}, 32'd0);
        chk("after rst state", {30'd0, bus.state}, {30'd0, S_ADDR});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
